// File: rtl/async_mult_ctrl.sv
// async_mult_ctrl: clocked sequencer for a self-timed multiplier.
// Four-phase req/ack handshake, synchronised ack, timeout abort.
module async_mult_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_req,
    input  logic               mul_ack,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_p,
    output logic               res_timeout,
    output logic [7:0]         res_cycles,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        REQ,
        RELEASE,
        DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic       ack_s1;
    logic       ack_s;
    logic [7:0] cnt;
    logic       accept;
    logic       tmo;

    assign accept    = cmd_valid && (state == IDLE);
    assign tmo       = (cnt == TMO_LAST);
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Two-flop synchroniser: the only sampler of the async ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= mul_ack;
            ack_s  <= ack_s1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: one transaction in flight at a time
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = LAUNCH;
            LAUNCH:  state_nx = REQ;
            REQ:     if (ack_s || tmo) state_nx = RELEASE;
            RELEASE: if (!ack_s) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered req (glitch-free) and operand latch held until next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_req <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            mul_req <= (state_nx == REQ);
            if (accept) begin
                mul_a <= cmd_a;
                mul_b <= cmd_b;
            end
        end
    end

    // Latency counter and result capture (product or timeout abort)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 8'd0;
            res_p       <= '0;
            res_timeout <= 1'b0;
            res_cycles  <= 8'd0;
        end else if (accept) begin
            cnt <= 8'd0;
        end else if (state == REQ) begin
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (ack_s) begin
                res_p       <= mul_p;
                res_cycles  <= cnt;
                res_timeout <= 1'b0;
            end else if (tmo) begin
                res_p       <= '0;
                res_cycles  <= 8'hFF;
                res_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/async_mult_ctrl.md
Name: async_mult_ctrl

Overview:
- Synchronous sequencer wrapping the self-timed (async) multiplier datapath inside tt_um_tommythorn_experiments.
- Accepts operand pairs on a valid/ready command port and drives the multiplier through a four-phase req/ack handshake.
- Synchronises the returning ack into the clk domain, captures the product and presents it on a valid/ready result port.
- Records handshake latency in cycles and aborts with a timeout flag if the multiplier never acknowledges.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- TIMEOUT, 255, max clk cycles in REQ waiting for ack before abort (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high (deliberately not rst_n: polarity is fixed high for this block)
- cmd_valid  in  1  operand pair valid
- cmd_ready  out  1  controller can accept a command
- cmd_a  in  WIDTH  multiplicand
- cmd_b  in  WIDTH  multiplier
- mul_a  out  WIDTH  registered operand A to async multiplier
- mul_b  out  WIDTH  registered operand B to async multiplier
- mul_req  out  1  four-phase request, registered, glitch-free
- mul_ack  in  1  four-phase acknowledge, asynchronous to clk
- mul_p  in  2*WIDTH  product (bundled data, valid while ack high)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_p  out  2*WIDTH  captured product (0 on timeout)
- res_timeout  out  1  result was aborted by timeout
- res_cycles  out  8  cycles from REQ entry to synchronised ack, saturating at 255
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; mul_req=0; mul_a=mul_b=0; res_valid=0; res_p=0; res_timeout=0; res_cycles=0; sync flops=0; timeout counter=0.
- ack_s = mul_ack through a 2-flop synchroniser: 2-cycle sync delay. No other logic samples mul_ack directly.
- cmd_ready = (state==IDLE). res_valid = (state==DONE). busy = (state!=IDLE).
- IDLE:
  - On cmd_valid & cmd_ready: latch cmd_a/cmd_b into mul_a/mul_b, clear counter, -> LAUNCH.
- LAUNCH:
  - One setup cycle; operands stable before req rises. -> REQ.
- REQ:
  - mul_req=1; counter increments each cycle (saturates at 255).
  - If ack_s=1: res_p<=mul_p, res_cycles<=counter, res_timeout<=0, -> RELEASE.
  - Else if counter==TIMEOUT-1: res_p<=0, res_cycles<=255, res_timeout<=1, -> RELEASE.
- RELEASE:
  - mul_req=0. Wait for ack_s=0 (return to zero). -> DONE.
  - After a timeout, if ack_s is already 0, exit next cycle.
- DONE:
  - Hold res_* stable. On res_ready: -> IDLE.
  - No new command is accepted in DONE: strictly one transaction in flight.
- mul_a/mul_b hold their value until the next accepted command, so operands stay stable through RELEASE.
- Product width is exactly 2*WIDTH; no truncation.
- Late ack after a timeout is absorbed by RELEASE; a second ack pulse arriving in DONE/IDLE is ignored.
- Reset mid-handshake forces mul_req=0 immediately. The async multiplier must tolerate req dropping before ack.
- Minimum transaction (ack already high on the first REQ sample): accept at cycle 0, req at cycle 2, capture at cycle 2+ack delay, res_valid at least 2 cycles after ack falls.

Test Plan:
- Reset, then cmd 3x5 with the multiplier model acking 4 ns after req -> res_p=0x000F, res_timeout=0, res_cycles=2 or 3, mul_req low before res_valid.
- cmd 0xFF x 0xFF -> res_p=0xFE01; cmd_ready=0 for the whole transaction; second cmd_valid held high is accepted only in the cycle after res_ready.
- Model never asserts ack, TIMEOUT=255 -> after 255 REQ cycles res_valid=1, res_p=0, res_timeout=1, res_cycles=255; then ack pulse injected -> ignored, state stays IDLE.
- Backpressure: res_ready=0 for 10 cycles after result 7x9 -> res_valid, res_p=0x003F held stable all 10 cycles; IDLE on first res_ready cycle.
- rst asserted while in REQ with mul_req=1 -> mul_req, res_valid, busy =0 without a clk edge; after release a 2x2 cmd -> res_p=0x0004.
- Ack asserted asynchronously mid-cycle with random skew over 100 random operand pairs -> every res_p equals a*b and no X on any output.
